// File: rtl/spi_keycode_responder.sv
// spi_keycode_responder
//   SPI mode-0 responder that runs entirely in the Clk domain. An external
//   controller writes the keycode and scratch bytes and reads back live
//   status and a constant device ID. Register 0 drives the keycode output,
//   and each committed write to it raises keycode_strobe for one Clk cycle.
//
//   Frame: a command byte {rw, 4'b0000, addr[2:0]} (rw=1 write), followed by
//   data bytes. The address auto-increments per byte and wraps 7 -> 0.
//   Register map: 0 keycode (rw), 1-5 scratch (rw), 6 status_in (ro),
//   7 DEV_ID (ro).
//
// Ports
//   Clk, Reset_n      system clock, asynchronous active-low reset
//   SPI_SCLK/SS_n/MOSI  SPI inputs from the master (synchronized here)
//   SPI_MISO, SPI_MISO_OE  serial data out and its pad enable
//   status_in         live status byte, read at register 6
//   keycode           register 0
//   keycode_strobe    one-cycle pulse after each write to register 0
//   busy              high while the synchronized SS_n is low
//   irq               (SPI_KEY_IRQ_EN only) set by keycode_strobe, cleared
//                     when a read frame loads register 0
//
// Optional feature: define SPI_KEY_IRQ_EN to add the irq output.
module spi_keycode_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEV_ID      = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       SPI_SCLK,
  input  logic       SPI_SS_n,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       SPI_MISO_OE,
  input  logic [7:0] status_in,
  output logic [7:0] keycode,
  output logic       keycode_strobe,
`ifdef SPI_KEY_IRQ_EN
  output logic       irq,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CMD    = 2'd1,
    S_DATA   = 2'd2,
    S_IGNORE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_sync_vld;
  logic                   r_sclk_prev;
  logic                   r_ss_prev;
  logic                   r_armed;

  logic       w_sclk, w_ss, w_mosi;
  logic       w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_last_rise;
  logic [7:0] w_rx_byte;

  logic [2:0] r_bitcnt;
  logic [6:0] r_shift_in;
  logic [6:0] r_shift_out;
  logic       r_miso;
  logic [2:0] r_addr;
  logic       r_wr;
  logic [7:0] r_regs [0:5];
  logic       r_strobe;

  logic       w_cmd_ok, w_commit, w_load;
  logic [2:0] w_load_addr;
  logic [7:0] w_rd_data;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss   = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_ss_rise   = w_ss & ~r_ss_prev;
  // The SS chain resets to 1, so a frame may only start once SS_n has been
  // genuinely seen high after reset (r_armed); a select held low across
  // reset release is ignored until it goes high and falls again.
  assign w_ss_fall   = r_armed & r_ss_prev & ~w_ss;
  assign w_last_rise = w_sclk_rise && (r_bitcnt == 3'd7);
  assign w_rx_byte   = {r_shift_in, w_mosi};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sync_vld  <= '0;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SPI_SS_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
      r_sclk_prev <= w_sclk;
      r_ss_prev   <= w_ss;
      if (r_sync_vld[SYNC_STAGES-1] && w_ss) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ok    = 1'b0;
    w_commit    = 1'b0;
    w_load      = 1'b0;
    w_load_addr = r_addr + 3'd1;
    unique case (r_state)
      S_IDLE: if (w_ss_fall) w_state_nxt = S_CMD;
      S_CMD: begin
        if (w_last_rise) begin
          if (w_rx_byte[6:3] == 4'd0) begin
            w_state_nxt = S_DATA;
            w_cmd_ok    = 1'b1;
            w_load      = ~w_rx_byte[7];
            w_load_addr = w_rx_byte[2:0];
          end else begin
            w_state_nxt = S_IGNORE;
          end
        end
      end
      S_DATA: begin
        if (w_last_rise) begin
          w_commit = r_wr;
          w_load   = ~r_wr;
        end
      end
      S_IGNORE: ;
      default: w_state_nxt = S_IDLE;
    endcase
    // A byte completing in the same cycle as deselect is still committed
    // above; only the state returns to IDLE here.
    if (r_state != S_IDLE && w_ss_rise) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_rd_data = DEV_ID;
    case (w_load_addr)
      3'd6:    w_rd_data = status_in;
      3'd7:    w_rd_data = DEV_ID;
      default: w_rd_data = r_regs[w_load_addr];
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_bitcnt    <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_miso      <= 1'b0;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_regs      <= '{default: '0};
      r_strobe    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_ss_fall) r_bitcnt <= '0;
      end else if (w_sclk_rise) begin
        r_bitcnt   <= r_bitcnt + 3'd1;
        r_shift_in <= w_rx_byte[6:0];
      end
      if (w_cmd_ok) begin
        r_wr   <= w_rx_byte[7];
        r_addr <= w_rx_byte[2:0];
      end
      if (w_commit) begin
        if (r_addr < 3'd6) r_regs[r_addr] <= w_rx_byte;
        r_strobe <= (r_addr == 3'd0);
        r_addr   <= r_addr + 3'd1;
      end
      // MSB goes out at load time; the fall that closes the loading byte
      // (bit counter already wrapped to 0) must not shift it away.
      if (w_load) begin
        r_shift_out <= w_rd_data[6:0];
        r_miso      <= w_rd_data[7];
        r_addr      <= w_load_addr;
      end else if (r_state == S_DATA && !r_wr && w_sclk_fall && r_bitcnt != 3'd0) begin
        r_shift_out <= {r_shift_out[5:0], 1'b0};
        r_miso      <= r_shift_out[6];
      end
      if (w_state_nxt != S_DATA) r_miso <= 1'b0;
    end
  end

`ifdef SPI_KEY_IRQ_EN
  logic r_irq;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                           r_irq <= 1'b0;
    else if (r_strobe)                      r_irq <= 1'b1;
    else if (w_load && w_load_addr == 3'd0) r_irq <= 1'b0;
  end
  assign irq = r_irq;
`endif

  assign keycode        = r_regs[0];
  assign keycode_strobe = r_strobe;
  assign busy           = ~w_ss;
  assign SPI_MISO_OE    = ~w_ss;
  assign SPI_MISO       = r_miso;

endmodule

// File: doc/spi_keycode_responder.md
Name: spi_keycode_responder

Overview:
- SPI mode-0 responder (slave) clocked in the system clock domain; the other end of the SoC's SPI master link.
- Lets an external controller on the Arduino header write keycodes and scratch bytes into a small register file and read back status/ID.
- keycode output feeds the game logic in parallel with the USB keycode path; a one-cycle strobe flags each new keycode.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on SCLK, SS_n and MOSI (minimum 2).
- DEV_ID, 8'hA5, constant returned when register 7 is read.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous active-low reset.
- SPI_SCLK  in  1  SPI clock from the master; must not exceed Clk/8.
- SPI_SS_n  in  1  chip select, active-low.
- SPI_MOSI  in  1  data from the master, MSB first.
- SPI_MISO  out  1  data to the master, MSB first.
- SPI_MISO_OE  out  1  tri-state enable for MISO; the top level drives the pad as Z when this is 0.
- status_in  in  8  live status byte, readable at register 6.
- keycode  out  8  contents of register 0.
- keycode_strobe  out  1  one-Clk pulse after each committed write to register 0.
- busy  out  1  high while the synchronized SS_n is low.

Behaviour:
- Reset values: keycode=0, keycode_strobe=0, busy=0, SPI_MISO=0, SPI_MISO_OE=0, registers 0-5 = 0, FSM in IDLE.
- Synchronization and edge detection:
  - SCLK, SS_n and MOSI each pass through SYNC_STAGES flip-flops.
  - Rise and fall of SCLK are detected from the synchronized value against its previous value.
  - A sampled bit is acted on within SYNC_STAGES+1 Clk cycles of the pin edge.
- Register map:
  - 0: keycode, read/write.
  - 1-5: scratch, read/write.
  - 6: status_in, read-only; writes are ignored.
  - 7: DEV_ID, read-only; writes are ignored.
- Frame format:
  - Command byte first: bit7 = 1 for write, 0 for read; bits6:3 must be 0; bits2:0 give the start address.
  - Data bytes follow, with the address auto-incrementing per byte and wrapping 7 -> 0.
- Bit timing:
  - MOSI is sampled on SCLK rise.
  - MISO shifts on SCLK fall.
  - A 3-bit counter tracks bits within the current byte.
- FSM:
  - IDLE: go to CMD on synchronized SS_n fall; clear the bit counter.
  - CMD: shift in 8 bits.
    - On the 8th rise with bits6:3 = 0: latch the address and R/W, go to DATA. For a read, load the shift register with reg[addr] and drive its MSB on MISO in the same cycle.
    - On the 8th rise with bits6:3 != 0: go to IGNORE.
  - DATA, write: on each 8th rise, commit the byte to reg[addr], then increment addr. A commit to address 0 produces keycode_strobe in the next Clk cycle.
  - DATA, read: on each 8th rise, load reg[addr+1] and advance addr. For reads, the address advances on the load. Register 6 is sampled from status_in at load time.
  - IGNORE: MISO is held at 0; no register writes.
  - Any state: SS_n rise returns the FSM to IDLE. A partial byte (bit counter != 0) is discarded with no commit and no strobe.
- MISO is 0 during the command byte. SPI_MISO_OE equals the synchronized ~SS_n.
- Simultaneous events: an SS_n rise and an 8th SCLK rise in the same Clk cycle still commit the byte, then return to IDLE.
- Reset asserted mid-frame: all state returns to reset values immediately. Once Reset_n is high, the next SS_n fall starts a fresh frame.
- If SS_n is already low when reset releases, the FSM stays in IDLE until SS_n goes high and falls again.

Optional Feature:
- Macro: SPI_KEY_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, reset 0).
  - irq sets on each keycode_strobe.
  - irq clears when a read frame loads register 0.
  - If set and clear occur in the same cycle, set wins.
- Undefined: the irq port and its logic are absent; all other behaviour is identical.

Test Plan:
- Write frame 0x80,0x1D at SCLK=Clk/10 -> keycode=0x1D, exactly one keycode_strobe pulse, register 1 unchanged.
- Read frame 0x07,0x00 -> master receives 0x00 during the command byte, then 0xA5; SPI_MISO_OE is high only while SS_n is low.
- Burst write 0x85,0x11,0x22,0x33,0x44 -> reg5=0x11, reg6 unchanged, reg7 still returns 0xA5, reg0=0x44 with one strobe (wrap 7 -> 0).
- Write 0x80 then 4 bits of 0xF, then SS_n high -> keycode unchanged, no strobe; the next full frame 0x80,0x04 yields keycode=0x04.
- Command 0x98 (bits6:3 != 0) followed by 0xFF -> all registers unchanged, MISO held at 0, no strobe.
- Assert Reset_n low after 12 SCLK bits of frame 0x81,0x55 -> all outputs return to reset values, reg1=0; a fresh frame reads reg1 back as 0x00; with SPI_KEY_IRQ_EN, irq=0.
